// File: rtl/imm_encoder.sv
// Packs a signed immediate into a RISC-V I/S/B/J instruction template.
// The result is registered and carries a range/alignment error flag.
module imm_encoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       ImmSrc,
  input  logic [31:0]      ImmVal,
  input  logic [31:0]      Base,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr,
  output logic             ImmErr,
  output logic [CNT_W-1:0] EncCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CHECK = 2'd1;
  localparam logic [1:0] PACK  = 2'd2;
  localparam logic [1:0] OUT   = 2'd3;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;

  logic [1:0]       state_q;
  logic [1:0]       src_q;
  logic [31:0]      val_q;
  logic [31:0]      base_q;
  logic [31:0]      instr_q, instr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q;

  // An immediate fits when the bits above its top field bit are a pure sign extension.
  always_comb begin
    err_d = 1'b0;
    case (src_q)
      FMT_I, FMT_S: err_d = !((&val_q[31:11]) || (~|val_q[31:11]));
      FMT_B:        err_d = !((&val_q[31:12]) || (~|val_q[31:12])) || val_q[0];
      default:      err_d = !((&val_q[31:20]) || (~|val_q[31:20])) || val_q[0];
    endcase
  end

  always_comb begin
    instr_d = base_q;
    case (src_q)
      FMT_I: instr_d[31:20] = val_q[11:0];
      FMT_S: begin
        instr_d[31:25] = val_q[11:5];
        instr_d[11:7]  = val_q[4:0];
      end
      FMT_B: begin
        instr_d[31]    = val_q[12];
        instr_d[30:25] = val_q[10:5];
        instr_d[11:8]  = val_q[4:1];
        instr_d[7]     = val_q[11];
      end
      default: begin
        instr_d[31]    = val_q[20];
        instr_d[30:21] = val_q[10:1];
        instr_d[20]    = val_q[11];
        instr_d[19:12] = val_q[19:12];
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      val_q   <= '0;
      base_q  <= '0;
      instr_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          src_q   <= ImmSrc;
          val_q   <= ImmVal;
          base_q  <= Base;
          state_q <= CHECK;
        end
        CHECK: begin
          err_q   <= err_d;
          state_q <= PACK;
        end
        PACK: begin
          instr_q <= instr_d;
          state_q <= OUT;
        end
        default: if (out_ready) begin
          cnt_q   <= cnt_q + CNT_W'(1);
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign out_valid = (state_q == OUT);
  assign Instr     = instr_q;
  assign ImmErr    = err_q;
  assign EncCount  = cnt_q;

endmodule

// File: tb/tb_imm_encoder.sv
// Directed plus random bench for imm_encoder, checked against a field-table packing model.
module tb_imm_encoder;

  logic        clk = 1'b0;
  logic        reset, in_valid, out_ready;
  logic [1:0]  ImmSrc;
  logic [31:0] ImmVal, Base;
  logic        in_ready, out_valid, ImmErr;
  logic [31:0] Instr;
  logic [15:0] EncCount;
  logic        in_ready2, out_valid2, ImmErr2;
  logic [31:0] Instr2;
  logic [1:0]  EncCount2;

  int checks = 0;
  int errors = 0;
  int unsigned cnt_m = 0;

  always #5 clk = ~clk;

  imm_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .ImmVal(ImmVal), .Base(Base), .out_valid(out_valid),
    .out_ready(out_ready), .Instr(Instr), .ImmErr(ImmErr), .EncCount(EncCount)
  );

  imm_encoder #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .ImmSrc(ImmSrc), .ImmVal(ImmVal), .Base(Base), .out_valid(out_valid2),
    .out_ready(out_ready), .Instr(Instr2), .ImmErr(ImmErr2), .EncCount(EncCount2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] place(input logic [31:0] r, input logic [31:0] v,
                                        input int dhi, input int dlo, input int slo);
    logic [31:0] t = r;
    for (int b = dlo; b <= dhi; b++) t[b] = v[slo + b - dlo];
    return t;
  endfunction

  function automatic logic [31:0] enc_model(input logic [1:0] f, input logic [31:0] v,
                                            input logic [31:0] base);
    logic [31:0] r = base;
    case (f)
      2'b00: r = place(r, v, 31, 20, 0);
      2'b01: begin r = place(r, v, 31, 25, 5); r = place(r, v, 11, 7, 0); end
      2'b10: begin
        r = place(r, v, 31, 31, 12); r = place(r, v, 30, 25, 5);
        r = place(r, v, 11, 8, 1);   r = place(r, v, 7, 7, 11);
      end
      default: begin
        r = place(r, v, 31, 31, 20); r = place(r, v, 30, 21, 1);
        r = place(r, v, 20, 20, 11); r = place(r, v, 19, 12, 12);
      end
    endcase
    return r;
  endfunction

  function automatic logic err_model(input logic [1:0] f, input logic [31:0] v);
    int signed s = $signed(v);
    case (f)
      2'b00, 2'b01: return (s < -2048) || (s > 2047);
      2'b10:        return (s < -4096) || (s > 4095) || (s % 2 != 0);
      default:      return (s < -1048576) || (s > 1048575) || (s % 2 != 0);
    endcase
  endfunction

  function automatic logic [31:0] decode(input logic [1:0] f, input logic [31:0] i);
    case (f)
      2'b00: return {{20{i[31]}}, i[31:20]};
      2'b01: return {{20{i[31]}}, i[31:25], i[11:7]};
      2'b10: return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endcase
  endfunction

  // One request: accept, latency, hold for 'hold' cycles under backpressure, then handshake.
  task automatic txn(input logic [1:0] f, input logic [31:0] v, input logic [31:0] base,
                     input int hold, input string tag);
    logic [31:0] exp_i = enc_model(f, v, base);
    logic        exp_e = err_model(f, v);
    int          waited = 0;
    ImmSrc = f; ImmVal = v; Base = base; in_valid = 1'b1; out_ready = 1'b0;
    while (!in_ready && waited < 10) begin step(); waited++; end
    check({tag, "_accept_ready"}, {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b1; ImmVal = $urandom; Base = $urandom;
    check({tag, "_busy_in_ready"}, {31'd0, in_ready}, 32'd0);
    step();
    check({tag, "_early_out_valid"}, {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, Instr, exp_i);
    check({tag, "_err"}, {31'd0, ImmErr}, {31'd0, exp_e});
    if (!exp_e) check({tag, "_roundtrip"}, decode(f, Instr), v);
    for (int c = 0; c < hold; c++) begin
      step();
      check({tag, "_hold_instr"}, Instr, exp_i);
      check({tag, "_hold_err"}, {31'd0, ImmErr}, {31'd0, exp_e});
      check({tag, "_hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      check({tag, "_hold_cnt"}, {16'd0, EncCount}, {16'd0, cnt_m[15:0]});
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    cnt_m++;
    check({tag, "_done_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_in_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_cnt"}, {16'd0, EncCount}, {16'd0, cnt_m[15:0]});
    check({tag, "_cnt_w2"}, {30'd0, EncCount2}, {30'd0, cnt_m[1:0]});
    check({tag, "_retain_instr"}, Instr, exp_i);
  endtask

  initial begin
    logic [1:0]  f;
    logic [31:0] v;
    int          w;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    ImmSrc = '0; ImmVal = '0; Base = '0;
    step(); step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_err", {31'd0, ImmErr}, 32'd0);
    check("rst_cnt", {16'd0, EncCount}, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    txn(2'b00, 32'hFFFF_FFFF, 32'h0000_0013, 0, "i_neg1");
    check("i_neg1_literal", Instr, 32'hFFF0_0013);
    txn(2'b10, 32'h0000_0010, 32'h0000_0063, 0, "b_16");
    check("b_16_literal", Instr, 32'h0000_0863);
    txn(2'b11, 32'h0000_0003, 32'h0000_006F, 0, "j_odd");
    check("j_odd_literal", Instr, 32'h0020_006F);
    check("j_odd_err_literal", {31'd0, ImmErr}, 32'd1);
    txn(2'b01, 32'h0000_0800, 32'h0000_2023, 5, "s_range");
    check("s_range_literal", Instr, 32'h8000_2023);
    check("wrap_w2_after4", {30'd0, EncCount2}, 32'd0);

    in_valid = 1'b1; ImmSrc = 2'b00; ImmVal = 32'd5; Base = 32'h13;
    step();
    in_valid = 1'b0; reset = 1'b1;
    step();
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_cnt", {16'd0, EncCount}, 32'd0);
    check("midrst_instr", Instr, 32'd0);
    reset = 1'b0; cnt_m = 0;
    step(); step(); step();
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_dropped", {31'd0, out_valid}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      f = 2'($urandom_range(0, 3));
      w = $urandom_range(1, 32);
      v = $urandom;
      if (w < 32) v = 32'($signed(v << (32 - w)) >>> (32 - w));
      if ($urandom_range(0, 1) == 1) v[0] = 1'b0;
      txn(f, v, $urandom, $urandom_range(0, 3), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
